rr_bus_arbiter: RTL and testbench

//  Round-robin bus arbiter for the shared system bus; replaces fixed master-1 priority.

---
 rtl/rr_bus_arbiter_pkg.sv | 14 +
 rtl/rr_priority_picker.sv | 21 ++
 rtl/rr_bus_arbiter.sv | 81 ++++++++
 tb/tb_rr_bus_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/rr_bus_arbiter_pkg.sv
// arb_pkg: FSM state encoding and sizing helper shared by the round-robin bus arbiter.
package arb_pkg;
   localparam logic [1:0] ARB_IDLE    = 2'd0;
   localparam logic [1:0] ARB_GRANT   = 2'd1;
   localparam logic [1:0] ARB_RELEASE = 2'd2;
   typedef enum logic [1:0] {
      ST_IDLE    = ARB_IDLE,
      ST_GRANT   = ARB_GRANT,
      ST_RELEASE = ARB_RELEASE
   } arb_state_e;
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: finds the first requester strictly after ptr, wrapping modulo N.
module rr_priority_picker #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         valid,
   output logic [W-1:0] idx
);
   logic [W-1:0] c;
   always_comb begin
      valid = |req;
      idx = '0;
      c = '0;
      for (int i = N; i >= 1; i--) begin
         c = W'((int'(ptr) + i) % N);
         if (req[c]) idx = c;
      end
   end
endmodule

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin bus arbiter with a one-cycle turnaround between tenures.
// Define ARB_HOLD_LIMIT_EN to bound a tenure to MAX_HOLD cycles while others are waiting.
module rr_bus_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_SLAVES  = 3,
   parameter int MAX_HOLD    = 16,
   parameter int MSEL_W      = clog2_min1(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NUM_MASTERS-1:0] breq,
   input  logic [NUM_SLAVES-1:0]  sready,
   output logic [NUM_MASTERS-1:0] bgrant,
   output logic [MSEL_W-1:0]      msel,
   output logic                   bus_busy,
   output logic                   preempt
);
   localparam logic [MSEL_W-1:0] LAST_RST = MSEL_W'(NUM_MASTERS - 1);
   if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || MAX_HOLD < 2) begin : g_bad_cfg
      $error("rr_bus_arbiter: unsupported parameter set");
   end
   arb_state_e             state_q;
   logic [MSEL_W-1:0]      owner_q, last_q, win;
   logic [NUM_MASTERS-1:0] bgrant_q;
   logic                   win_valid, start_d, drop_d, preempt_d;
   rr_priority_picker #(.N(NUM_MASTERS), .W(MSEL_W)) u_picker (
      .req  (breq),
      .ptr  (last_q),
      .valid(win_valid),
      .idx  (win)
   );
   assign start_d = win_valid && &sready;
   assign drop_d  = !breq[owner_q];
`ifdef ARB_HOLD_LIMIT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   logic [HOLD_W-1:0] hold_q;
   logic              preempt_q;
   assign preempt_d = hold_q == HOLD_W'(MAX_HOLD) && |(breq & ~bgrant_q);
   assign preempt   = preempt_q;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         preempt_q <= state_q == ST_GRANT && !drop_d && preempt_d;
         hold_q    <= (state_q == ST_IDLE && start_d) ? HOLD_W'(1)
                    : (state_q == ST_GRANT && hold_q != HOLD_W'(MAX_HOLD)) ? hold_q + 1'b1 : hold_q;
      end
   end
`else
   assign preempt_d = 1'b0;
   assign preempt   = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         last_q   <= LAST_RST;
         bgrant_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (start_d) begin
               state_q  <= ST_GRANT;
               owner_q  <= win;
               bgrant_q <= NUM_MASTERS'(1) << win;
            end
            ST_GRANT: if (drop_d || preempt_d) begin
               state_q  <= ST_RELEASE;
               last_q   <= owner_q;
               bgrant_q <= '0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
   assign bgrant   = bgrant_q;
   assign msel     = owner_q;
   assign bus_busy = state_q != ST_IDLE;
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: directed vectors with a queued scoreboard for the round-robin arbiter.
module tb_rr_bus_arbiter;
   localparam int NM = 2;
   localparam int NS = 3;
   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [NM-1:0] breq = '0;
   logic [NS-1:0] sready = '0;
   logic [NM-1:0] bgrant;
   logic [0:0]    msel;
   logic          bus_busy, preempt;
   int            total = 0;
   int            bad = 0;
   logic [4:0]    exp_q[$];
   string         name_q[$];
   always #5 clk = ~clk;
   rr_bus_arbiter #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .MAX_HOLD(4)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .breq    (breq),
      .sready  (sready),
      .bgrant  (bgrant),
      .msel    (msel),
      .bus_busy(bus_busy),
      .preempt (preempt)
   );
   // e = {bgrant, msel, bus_busy, preempt} expected right after the next rising edge
   task automatic step(input string nm, input logic r, input logic [1:0] b, input logic [2:0] s,
                       input logic [4:0] e);
      rstn = r;
      breq = b;
      sready = s;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask
   initial begin : monitor
      logic [4:0] e, a;
      logic [1:0] prev_g;
      string nm;
      prev_g = '0;
      forever begin
         @(negedge clk);
         a = {bgrant, msel, bus_busy, preempt};
         total++;
         if (!$onehot0(bgrant)) begin
            bad++;
            $display("FAIL onehot: bgrant=%b, required one-hot or zero", bgrant);
         end
         total++;
         if (prev_g != 2'b00 && bgrant != 2'b00 && bgrant != prev_g) begin
            bad++;
            $display("FAIL turnaround: bgrant went %b -> %b, required a zero cycle between", prev_g, bgrant);
         end
         prev_g = bgrant;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL %s: got g=%b m=%b busy=%b pre=%b, required g=%b m=%b busy=%b pre=%b",
                        nm, a[4:3], a[2], a[1], a[0], e[4:3], e[2], e[1], e[0]);
            end
         end
      end
   end
   initial begin : driver
      step("reset0", 1'b0, 2'b11, 3'b111, 5'b00_0_0_0);
      step("reset1", 1'b0, 2'b11, 3'b111, 5'b00_0_0_0);
      step("first_m0", 1'b1, 2'b11, 3'b111, 5'b01_0_1_0);
      step("m0_hold", 1'b1, 2'b11, 3'b111, 5'b01_0_1_0);
      step("m0_hold", 1'b1, 2'b11, 3'b111, 5'b01_0_1_0);
      step("m0_release", 1'b1, 2'b10, 3'b111, 5'b00_0_1_0);
      step("idle_gap", 1'b1, 2'b10, 3'b111, 5'b00_0_0_0);
      step("alt_m1", 1'b1, 2'b10, 3'b111, 5'b10_1_1_0);
      step("m1_sready0", 1'b1, 2'b10, 3'b000, 5'b10_1_1_0);
      step("m1_sready1", 1'b1, 2'b10, 3'b010, 5'b10_1_1_0);
      step("m1_sready2", 1'b1, 2'b10, 3'b000, 5'b10_1_1_0);
      step("m1_release", 1'b1, 2'b00, 3'b000, 5'b00_1_1_0);
      step("msel_hold", 1'b1, 2'b00, 3'b111, 5'b00_1_0_0);
      step("not_ready0", 1'b1, 2'b01, 3'b101, 5'b00_1_0_0);
      step("not_ready1", 1'b1, 2'b01, 3'b101, 5'b00_1_0_0);
      step("ready_m0", 1'b1, 2'b01, 3'b111, 5'b01_0_1_0);
      step("m0_rel", 1'b1, 2'b00, 3'b111, 5'b00_0_1_0);
      step("m0_idle", 1'b1, 2'b00, 3'b111, 5'b00_0_0_0);
      step("rr_m1", 1'b1, 2'b11, 3'b111, 5'b10_1_1_0);
      step("rst_in_grant", 1'b0, 2'b11, 3'b111, 5'b00_0_0_0);
      step("post_rst_m0", 1'b1, 2'b11, 3'b111, 5'b01_0_1_0);
      step("both_drop", 1'b1, 2'b00, 3'b111, 5'b00_0_1_0);
      step("both_idle", 1'b1, 2'b00, 3'b111, 5'b00_0_0_0);
      step("min_tenure", 1'b1, 2'b01, 3'b111, 5'b01_0_1_0);
      step("min_rel", 1'b1, 2'b00, 3'b111, 5'b00_0_1_0);
      step("min_idle", 1'b1, 2'b00, 3'b111, 5'b00_0_0_0);
      step("reset2", 1'b0, 2'b00, 3'b111, 5'b00_0_0_0);
      step("hold_g1", 1'b1, 2'b11, 3'b111, 5'b01_0_1_0);
      step("hold_g2", 1'b1, 2'b11, 3'b111, 5'b01_0_1_0);
      step("hold_g3", 1'b1, 2'b11, 3'b111, 5'b01_0_1_0);
      step("hold_g4", 1'b1, 2'b11, 3'b111, 5'b01_0_1_0);
`ifdef ARB_HOLD_LIMIT_EN
      step("preempt", 1'b1, 2'b11, 3'b111, 5'b00_0_1_1);
      step("preempt_idle", 1'b1, 2'b11, 3'b111, 5'b00_0_0_0);
      step("preempt_m1", 1'b1, 2'b11, 3'b111, 5'b10_1_1_0);
      step("pm1_rel", 1'b1, 2'b00, 3'b111, 5'b00_1_1_0);
      step("pm1_idle", 1'b1, 2'b00, 3'b111, 5'b00_1_0_0);
`else
      step("no_limit5", 1'b1, 2'b11, 3'b111, 5'b01_0_1_0);
      step("no_limit6", 1'b1, 2'b11, 3'b111, 5'b01_0_1_0);
      step("no_limit7", 1'b1, 2'b11, 3'b111, 5'b01_0_1_0);
      step("nl_rel", 1'b1, 2'b00, 3'b111, 5'b00_0_1_0);
      step("nl_idle", 1'b1, 2'b00, 3'b111, 5'b00_0_0_0);
`endif
      step("sole_grant", 1'b1, 2'b01, 3'b111, 5'b01_0_1_0);
      for (int i = 0; i < 20; i++) step("sole_hold", 1'b1, 2'b01, 3'b111, 5'b01_0_1_0);
      step("sole_rel", 1'b1, 2'b00, 3'b111, 5'b00_0_1_0);
      step("sole_idle", 1'b1, 2'b00, 3'b111, 5'b00_0_0_0);
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
